// File: rtl/rgb_window_pkg.sv
// Shared constants, window-origin helper and FSM state encoding for the RGB window transmitter.
// Defaults describe a 10x10 window centred in a 640x480 frame.
package rgb_window_pkg;

  function automatic int win_start(input int active, input int size);
    return (active - size) / 2;
  endfunction

  localparam int X_START = win_start(640, 10);
  localparam int Y_START = win_start(480, 10);
  localparam int NPIX    = 100;
  localparam int NBYTES  = 3 * NPIX;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } state_e;

endpackage

// File: rtl/pixel_buf.sv
// Window pixel store: one synchronous write port, one read port with 1-cycle latency.
// Read data holds its value while rd_en is low; contents are never reset.
module pixel_buf
  import rgb_window_pkg::*;
#(
  parameter int DEPTH = NPIX,
  parameter int AW    = $clog2(NPIX),
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/rgb_window_tx.sv
// Captures a centred window from one camera frame, then streams it as R,G,B bytes.
// First byte 2 cycles after the last window pixel; valid/ready, data held while stalled.
module rgb_window_tx
  import rgb_window_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WIDTH    = 10,
  parameter int HEIGHT   = 10
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iRed,
  input  logic [11:0] iGreen,
  input  logic [11:0] iBlue,
  input  logic        iDVAL,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic        iSTART,
  input  logic        iREADY,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic        oBUSY,
  output logic        oDONE
);

  localparam int XS = win_start(H_ACTIVE, WIDTH);
  localparam int YS = win_start(V_ACTIVE, HEIGHT);
  localparam int XE = XS + WIDTH - 1;
  localparam int YE = YS + HEIGHT - 1;
  localparam int NP = WIDTH * HEIGHT;
  localparam int NB = 3 * NP;
  localparam int AW = $clog2(NP);
  localparam int BW = $clog2(NB);

  state_e        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_last_q, rd_last_d;
  logic          pix_vld_q, pix_vld_d;
  logic [1:0]    sel_q, sel_d;
  logic [7:0]    out_dat_q, out_dat_d;
  logic          out_vld_q, out_vld_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;

  logic          in_win, frame_start, last_pix, wr_en, rd_en, load, accept;
  logic [10:0]   x_loc, y_loc, lin;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data, rd_data;
  logic          unused_lsbs;

  assign unused_lsbs = ^{iRed[3:0], iGreen[3:0], iBlue[3:0]};

  always_comb begin
    x_loc       = iX_Cont - 11'(XS);
    y_loc       = iY_Cont - 11'(YS);
    lin         = y_loc * 11'(WIDTH) + x_loc;
    wr_addr     = AW'(lin);
    wr_data     = {iRed[11:4], iGreen[11:4], iBlue[11:4]};
    in_win      = (iX_Cont >= 11'(XS)) && (iX_Cont <= 11'(XE)) &&
                  (iY_Cont >= 11'(YS)) && (iY_Cont <= 11'(YE));
    frame_start = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
    last_pix    = iDVAL && (iX_Cont == 11'(XE)) && (iY_Cont == 11'(YE));
    wr_en       = (state_q == ST_CAPTURE) && iDVAL && in_win;
  end

  pixel_buf #(.DEPTH(NP), .AW(AW), .DW(24)) u_buf (
    .clk     (iCLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (iSTART) state_d = ST_SYNC;
      ST_SYNC:    if (frame_start) state_d = ST_CAPTURE;
      ST_CAPTURE: if (last_pix) state_d = ST_SEND;
      ST_SEND:    if (accept && (byte_cnt_q == BW'(NB - 1))) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    oBUSY = (state_q != ST_IDLE);
    oDONE = (state_q == ST_DONE);
  end

  // The read data register doubles as the prefetch stage: the next pixel is
  // fetched in the same cycle its predecessor's blue byte moves to the output.
  always_comb begin
    accept     = out_vld_q && iREADY;
    load       = (state_q == ST_SEND) && pix_vld_q && (!out_vld_q || iREADY);
    rd_en      = (state_q == ST_SEND) && !rd_last_q &&
                 (!pix_vld_q || (load && (sel_q == 2'd2)));
    rd_addr_d  = rd_addr_q;
    rd_last_d  = rd_last_q;
    pix_vld_d  = pix_vld_q;
    sel_d      = sel_q;
    out_dat_d  = out_dat_q;
    out_vld_d  = out_vld_q;
    byte_cnt_d = byte_cnt_q;
    if (state_q != ST_SEND) begin
      rd_addr_d  = '0;
      rd_last_d  = 1'b0;
      pix_vld_d  = 1'b0;
      sel_d      = 2'd0;
      out_vld_d  = 1'b0;
      byte_cnt_d = '0;
    end else begin
      if (rd_en) begin
        rd_last_d = (rd_addr_q == AW'(NP - 1));
        if (rd_addr_q != AW'(NP - 1)) rd_addr_d = rd_addr_q + 1'b1;
      end
      if (rd_en)                            pix_vld_d = 1'b1;
      else if (load && (sel_q == 2'd2))     pix_vld_d = 1'b0;
      if (load) begin
        case (sel_q)
          2'd0:    out_dat_d = rd_data[23:16];
          2'd1:    out_dat_d = rd_data[15:8];
          default: out_dat_d = rd_data[7:0];
        endcase
        sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 1'b1;
      end
      if (load)        out_vld_d = 1'b1;
      else if (accept) out_vld_d = 1'b0;
      if (accept && (byte_cnt_q != BW'(NB - 1))) byte_cnt_d = byte_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
      pix_vld_q  <= 1'b0;
      sel_q      <= 2'd0;
      out_dat_q  <= 8'd0;
      out_vld_q  <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_last_q  <= rd_last_d;
      pix_vld_q  <= pix_vld_d;
      sel_q      <= sel_d;
      out_dat_q  <= out_dat_d;
      out_vld_q  <= out_vld_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign oDATA = {4'b0000, out_dat_q};
  assign oDVAL = out_vld_q;

endmodule

// File: tb/tb_rgb_window_tx.sv
// Bench for rgb_window_tx: sparse camera frames around the window, expected bytes
// queued at stimulus time and popped by a negedge monitor on every handshake.
module tb_rgb_window_tx;

  localparam int XS = 315;
  localparam int YS = 235;
  localparam int XE = 324;
  localparam int YE = 244;
  localparam int LIMIT = 3000;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [11:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic        iDVAL = 1'b0;
  logic [10:0] iX_Cont = '0, iY_Cont = '0;
  logic        iSTART = 1'b0;
  logic        iREADY = 1'b1;
  logic [11:0] oDATA;
  logic        oDVAL, oBUSY, oDONE;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int xfer_cnt = 0, done_cnt = 0, vld_rise_cyc = 0, last_acc_cyc = 0, last_px_cyc = 0;
  logic [7:0] sb[$];
  logic rdy_toggle = 1'b0;
  logic prev_stall = 1'b0, prev_dval = 1'b0;
  logic [11:0] prev_data = '0;

  rgb_window_tx #(.H_ACTIVE(640), .V_ACTIVE(480), .WIDTH(10), .HEIGHT(10)) dut (
    .iCLK(iCLK), .iRST(iRST), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iSTART(iSTART),
    .iREADY(iREADY), .oDATA(oDATA), .oDVAL(oDVAL), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  always @(posedge iCLK) begin
    #1;
    if (rdy_toggle) iREADY = !iREADY;
    else            iREADY = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge iCLK) begin
    logic [7:0] e;
    if (iRST) begin
      sb.delete();
    end else begin
      if (prev_stall) chk("hold_stable", {20'b0, oDATA}, {20'b0, prev_data});
      if (oDVAL && !prev_dval) vld_rise_cyc = cyc;
      if (oDVAL && iREADY) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL byte_unexpected: got 0x%0h with nothing expected (cycle %0d)", oDATA, cyc);
        end else begin
          e = sb.pop_front();
          chk("byte", {20'b0, oDATA}, {24'b0, e});
        end
        xfer_cnt++;
        last_acc_cyc = cyc;
      end
      if (oDONE) begin
        done_cnt++;
        chk("dval_low_in_done", {31'b0, oDVAL}, 32'd0);
      end
    end
    prev_stall = !iRST && oDVAL && !iREADY;
    prev_dval  = !iRST && oDVAL;
    prev_data  = oDATA;
  end

  function automatic logic [23:0] pxv(input int mode, input int x, input int y);
    int k;
    logic [7:0] kb;
    if (x < XS || x > XE || y < YS || y > YE) return 24'hF00F77;
    k  = (y - YS) * 10 + (x - XS);
    kb = 8'(k);
    case (mode)
      0:       return 24'hABCDEF;
      1:       return {kb, kb, kb};
      2:       return {kb, 8'(k + 100), 8'(255 - k)};
      default: return 24'h5A3C96;
    endcase
  endfunction

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive_px(input int mode, input int x, input int y, input logic v);
    logic [23:0] p;
    logic [3:0]  lo;
    p  = pxv(mode, x, y);
    lo = (mode == 0) ? 4'h0 : 4'(x);
    iRed    = {p[23:16], lo};
    iGreen  = {p[15:8], lo};
    iBlue   = {p[7:0], lo};
    iX_Cont = 11'(x);
    iY_Cont = 11'(y);
    iDVAL   = v;
    if (v && x == XE && y == YE) last_px_cyc = cyc;
    step();
  endtask

  task automatic frame(input int mode);
    drive_px(3, 0, 0, 1'b1);
    drive_px(3, XS, YS, 1'b0);
    for (int y = YS - 2; y <= YE + 2; y++)
      for (int x = XS - 2; x <= XE + 2; x++) begin
        if (x == XS + 3) drive_px(3, x, y, 1'b0);
        drive_px(mode, x, y, 1'b1);
      end
    iDVAL = 1'b0;
  endtask

  task automatic push_exp(input int mode);
    logic [23:0] p;
    for (int k = 0; k < 100; k++) begin
      p = pxv(mode, XS + k % 10, YS + k / 10);
      sb.push_back(p[23:16]);
      sb.push_back(p[15:8]);
      sb.push_back(p[7:0]);
    end
  endtask

  task automatic start_pulse();
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input int x0, input int d0, input logic gapless);
    int t = 0;
    while (done_cnt == d0 && t < LIMIT) begin
      step();
      t++;
    end
    chk({tag, "_done_timeout"}, 32'(t >= LIMIT), 32'd0);
    repeat (3) step();
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_byte_count"}, 32'(xfer_cnt - x0), 32'd300);
    chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    chk({tag, "_idle_busy"}, {31'b0, oBUSY}, 32'd0);
    if (gapless) chk({tag, "_span"}, 32'(last_acc_cyc - vld_rise_cyc + 1), 32'd300);
  endtask

  initial begin
    int x0, d0, t;
    repeat (3) step();
    @(negedge iCLK);
    chk("rst_dval", {31'b0, oDVAL}, 32'd0);
    chk("rst_busy", {31'b0, oBUSY}, 32'd0);
    chk("rst_done", {31'b0, oDONE}, 32'd0);
    chk("rst_data", {20'b0, oDATA}, 32'd0);
    step();
    iRST = 1'b0;
    step();

    // Constant colour frame
    x0 = xfer_cnt; d0 = done_cnt;
    push_exp(0);
    start_pulse();
    chk("start_busy", {31'b0, oBUSY}, 32'd1);
    frame(0);
    finish_xfer("const", x0, d0, 1'b1);

    // Gradient frame with first-valid latency
    x0 = xfer_cnt; d0 = done_cnt;
    push_exp(1);
    start_pulse();
    frame(1);
    finish_xfer("grad", x0, d0, 1'b1);
    chk("grad_first_dval_cyc", 32'(vld_rise_cyc), 32'(last_px_cyc + 3));

    // Toggling ready
    rdy_toggle = 1'b1;
    x0 = xfer_cnt; d0 = done_cnt;
    push_exp(2);
    start_pulse();
    frame(2);
    finish_xfer("toggle", x0, d0, 1'b0);
    rdy_toggle = 1'b0;
    step();

    // Start mid-frame: window rows of the current frame must not be captured
    x0 = xfer_cnt; d0 = done_cnt;
    push_exp(1);
    for (int x = 300; x <= 330; x++) begin
      iSTART = (x == 310);
      drive_px(3, x, 240, 1'b1);
    end
    iSTART = 1'b0;
    chk("midframe_sync_busy", {31'b0, oBUSY}, 32'd1);
    for (int y = 241; y <= 246; y++)
      for (int x = 313; x <= 326; x++) drive_px(3, x, y, 1'b1);
    frame(1);
    finish_xfer("midframe", x0, d0, 1'b1);

    // Reset after 150 bytes, then a full transfer
    x0 = xfer_cnt; d0 = done_cnt;
    push_exp(0);
    start_pulse();
    frame(0);
    t = 0;
    while (xfer_cnt - x0 < 150 && t < LIMIT) begin
      step();
      t++;
    end
    chk("rstmid_wait_timeout", 32'(t >= LIMIT), 32'd0);
    chk("rstmid_bytes_before", 32'(xfer_cnt - x0), 32'd150);
    iRST = 1'b1;
    step();
    chk("rstmid_dval", {31'b0, oDVAL}, 32'd0);
    chk("rstmid_busy", {31'b0, oBUSY}, 32'd0);
    chk("rstmid_data", {20'b0, oDATA}, 32'd0);
    iRST = 1'b0;
    step();
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    x0 = xfer_cnt; d0 = done_cnt;
    push_exp(0);
    start_pulse();
    frame(0);
    finish_xfer("after_rst", x0, d0, 1'b1);

    // Second start during SEND must be ignored
    x0 = xfer_cnt; d0 = done_cnt;
    push_exp(1);
    start_pulse();
    frame(1);
    repeat (20) step();
    chk("restart_in_send", {31'b0, oBUSY}, 32'd1);
    start_pulse();
    finish_xfer("restart", x0, d0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_window_tx.md
RGB_WINDOW_TX -- requirements
Module: rgb_window_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter WIDTH, default 10, meaning window width in pixels.
REQ-004 SHALL have parameter HEIGHT, default 10, meaning window height in lines.
REQ-005 SHALL have port iCLK  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port iRST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port iRed / iGreen / iBlue  input  12 each  camera pixel colour.
REQ-008 SHALL have port iDVAL  input  1  camera pixel valid strobe.
REQ-009 SHALL have port iX_Cont / iY_Cont  input  11 each  pixel coordinates 0..639 / 0..479.
REQ-010 SHALL have port iSTART  input  1  one-cycle pulse that arms one capture-and-send.
REQ-011 SHALL have port iREADY  input  1  sink accepts the current byte.
REQ-012 SHALL have port oDATA  output  12  byte in [7:0]; [11:8] always 0.
REQ-013 SHALL have port oDVAL  output  1  oDATA valid.
REQ-014 SHALL have port oBUSY  output  1  high in every state except IDLE.
REQ-015 SHALL have port oDONE  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-016 SHALL use X_START=(H_ACTIVE-WIDTH)/2=315 and Y_START=(V_ACTIVE-HEIGHT)/2=235.
REQ-017 SHALL implement FSM states IDLE, SYNC, CAPTURE, SEND, DONE.
REQ-018 IDLE->SYNC SHALL occur on iSTART=1; iSTART in any other state SHALL be ignored.
REQ-019 SYNC->CAPTURE SHALL occur on a cycle with iDVAL=1, iX_Cont=0, iY_Cont=0 (frame start), so the whole window comes from one frame.
REQ-020 In CAPTURE, each cycle with iDVAL=1 and the pixel inside the window SHALL write {iRed[11:4],iGreen[11:4],iBlue[11:4]} to buffer entry (iY_Cont-Y_START)*WIDTH+(iX_Cont-X_START).
REQ-021 CAPTURE->SEND SHALL occur on the cycle that samples pixel (X_START+WIDTH-1, Y_START+HEIGHT-1) with iDVAL=1.
REQ-022 SEND SHALL emit 3*WIDTH*HEIGHT=300 bytes: pixels 0..99 in row-major order, R then G then B per pixel.
REQ-023 A byte SHALL transfer on a cycle with oDVAL=1 and iREADY=1.
REQ-024 oDATA SHALL hold stable while oDVAL=1 and iREADY=0.
REQ-025 oDVAL SHALL first assert exactly 2 cycles after the cycle that samples the last window pixel.
REQ-026 With iREADY held at 1, SEND SHALL deliver one byte per cycle with no gaps (300 consecutive cycles).
REQ-027 On acceptance of byte 299, the FSM SHALL enter DONE; oDVAL SHALL be 0 the next cycle.
REQ-028 DONE SHALL assert oDONE for exactly one cycle and then return to IDLE.
REQ-029 Byte and pixel counters SHALL reset to 0 on entering SEND and SHALL never exceed 299 / 99.
REQ-030 iDVAL and camera inputs SHALL be ignored in IDLE, SEND and DONE.
REQ-031 Buffer contents SHALL persist until overwritten by the next CAPTURE.

Reset
REQ-032 iRST=1 at a clock edge SHALL force IDLE, oDVAL=0, oDONE=0, oBUSY=0, oDATA=0, and all counters to 0, from any state including mid-SEND.
REQ-033 Buffer contents SHALL NOT be reset.

Structure
REQ-034 A shared package rgb_window_pkg SHALL hold X_START/Y_START derivation, NPIX=100, NBYTES=300, and the state enum.
REQ-035 Storage SHALL be a sub-module pixel_buf: 100x24 memory with one synchronous write port and one read port with 1-cycle read latency.
REQ-036 The output byte path SHALL be registered, with a prefetch stage to meet REQ-026.

Verification
REQ-037 Constant-colour frame R=0xAB0, G=0xCD0, B=0xEF0, iSTART, iREADY=1 -> 300 bytes repeating AB,CD,EF; oDONE pulses once.
REQ-038 Gradient frame, pixel value = 8-bit (y_local*10+x_local) on all channels -> byte 3k..3k+2 = k for k=0..99; bytes 0..2 first; first oDVAL 2 cycles after pixel (324,244).
REQ-039 iREADY toggled 1,0,1,0 -> oDATA stable during every iREADY=0 cycle; exactly 300 transfers; no byte lost or duplicated.
REQ-040 iSTART issued while iY_Cont=240 -> no writes until next frame start; window captured entirely from the next frame.
REQ-041 iRST=1 after byte 150 -> next cycle IDLE with oDVAL=0 and oBUSY=0; a new iSTART yields a full 300-byte transfer.
REQ-042 Second iSTART during SEND -> ignored; exactly one oDONE pulse.
